mdu_ctrl: RTL and testbench

//  Multiply/divide unit controller for the 5-stage pipeline, sitting in the E stage beside the ALU.

---
 rtl/mdu_ctrl_if.sv | 27 ++
 rtl/mdu_ctrl.sv | 151 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage <-> multiply/divide unit signal bundle.
//   master : pipeline side (drives start/op/operands/md_in_d, reads status and HI/LO)
//   slave  : mdu_ctrl side
//   start    1  E-stage instr is an MDU op this cycle
//   op       3  0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 fastdiv,7 reserved
//   rs_val  32  forwarded rs operand
//   rt_val  32  forwarded rt operand
//   md_in_d  1  D-stage instr is mult/div/mf/mt class
//   busy     1  multi-cycle op in progress
//   stall_md 1  hold D-stage md-class instr
//   hi/lo   32  committed HI/LO registers
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_in_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, md_in_d,
                  input  busy, stall_md, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, md_in_d,
                  output busy, stall_md, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller in the E stage.
// Computes the 64-bit mult/div result at issue, holds it as a pending value
// while a busy counter models the unit latency, then commits HI/LO on the
// edge that ends busy. Drives stall_md for md-class instructions in D.
// Ports: clk, reset (sync, active-high), mdu (mdu_ctrl_if.slave).
// Optional feature: define MDU_FASTDIV_EN to enable op 6 (fastdiv, unsigned
// divide with FASTDIV_CYCLES latency); otherwise op 6 is a reserved no-op.
module mdu_ctrl #(
  parameter int MULT_CYCLES    = 5,
  parameter int DIV_CYCLES     = 10,
  parameter int FASTDIV_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  mdu
);

  localparam int MAX0 = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MAXC = (MAX0 > FASTDIV_CYCLES) ? MAX0 : FASTDIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_FASTDIV_EN
  localparam logic [2:0] OP_FDIV  = 3'd6;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  // Pending result; wr=0 marks a divide by zero, which must not touch HI/LO.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } pend_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pend_t         pend_q, pend_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // ---------------- datapath ----------------
  logic [63:0] mul_s, mul_u;
  logic [31:0] dvs, uq, ur;
  logic [31:0] a_mag, b_mag, sq, sr, q_s, r_s;

  assign mul_s = $signed({{32{mdu.rs_val[31]}}, mdu.rs_val}) *
                 $signed({{32{mdu.rt_val[31]}}, mdu.rt_val});
  assign mul_u = {32'd0, mdu.rs_val} * {32'd0, mdu.rt_val};

  // Divisor forced to 1 on zero so the dividers never see /0; the result is
  // discarded anyway via pend.wr.
  assign dvs   = (mdu.rt_val == 32'd0) ? 32'd1 : mdu.rt_val;
  assign uq    = mdu.rs_val / dvs;
  assign ur    = mdu.rs_val % dvs;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000/-1 falls out as lo=0x80000000, hi=0.
  assign a_mag = mdu.rs_val[31] ? (32'd0 - mdu.rs_val) : mdu.rs_val;
  assign b_mag = dvs[31] ? (32'd0 - dvs) : dvs;
  assign sq    = a_mag / b_mag;
  assign sr    = a_mag % b_mag;
  assign q_s   = (mdu.rs_val[31] ^ dvs[31]) ? (32'd0 - sq) : sq;
  assign r_s   = mdu.rs_val[31] ? (32'd0 - sr) : sr;

  // ---------------- op decode ----------------
  logic          is_mc;
  logic [CW-1:0] cyc;
  pend_t         res;

  always_comb begin
    is_mc = 1'b0;
    cyc   = '0;
    res   = '0;
    case (mdu.op)
      OP_MULT:  begin is_mc = 1'b1; cyc = CW'(MULT_CYCLES); res = '{mul_s[63:32], mul_s[31:0], 1'b1}; end
      OP_MULTU: begin is_mc = 1'b1; cyc = CW'(MULT_CYCLES); res = '{mul_u[63:32], mul_u[31:0], 1'b1}; end
      OP_DIV:   begin is_mc = 1'b1; cyc = CW'(DIV_CYCLES);  res = '{r_s, q_s, (mdu.rt_val != 32'd0)}; end
      OP_DIVU:  begin is_mc = 1'b1; cyc = CW'(DIV_CYCLES);  res = '{ur, uq, (mdu.rt_val != 32'd0)}; end
`ifdef MDU_FASTDIV_EN
      OP_FDIV:  begin is_mc = 1'b1; cyc = CW'(FASTDIV_CYCLES); res = '{ur, uq, (mdu.rt_val != 32'd0)}; end
`endif
      default: ;
    endcase
  end

  logic start_mc;
  assign start_mc = mdu.start & is_mc;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_mc) begin
          state_d = RUN;
          cnt_d   = cyc;
          pend_d  = res;
        end else if (mdu.start && mdu.op == OP_MTHI) begin
          hi_d = mdu.rs_val;
        end else if (mdu.start && mdu.op == OP_MTLO) begin
          lo_d = mdu.rs_val;
        end
      end
      RUN: begin
        // Any start here is ignored; the pipeline stalls it in D.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          pend_d  = '0;
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.busy     = (state_q == RUN);
  assign mdu.stall_md = mdu.md_in_d & (mdu.busy | start_mc);
  assign mdu.hi       = hi_q;
  assign mdu.lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl. Expected HI/LO pairs are
// pushed to a scoreboard queue at issue and popped when busy drops.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if mif();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .FASTDIV_CYCLES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (mif)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  // Reference model using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs, rt,
                                        input logic [31:0] chi, clo);
    longint a, b, q, r;
    logic [63:0] qv, rv;
    case (op)
      3'd0: begin a = longint'($signed(rs)); b = longint'($signed(rt)); q = a * b; return q; end
      3'd1: return {32'd0, rs} * {32'd0, rt};
      3'd2: begin
        if (rt == 0) return {chi, clo};
        a = longint'($signed(rs)); b = longint'($signed(rt));
        q = a / b; r = a % b; qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (rt == 0) return {chi, clo};
        return {rs % rt, rs / rt};
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, rt, input logic [63:0] exp);
    mif.start = 1'b1; mif.op = op; mif.rs_val = rs; mif.rt_val = rt;
    sb_q.push_back(exp);
    tick;
    mif.start = 1'b0;
  endtask

  // Counts busy cycles (bounded); flags HI/LO changing before commit.
  task automatic run_busy(output int n, output bit leak);
    n = 0; leak = 1'b0;
    while (mif.busy && n < 100) begin
      n++;
      if (mif.hi !== m_hi || mif.lo !== m_lo) leak = 1'b1;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mif.start = 0; mif.op = 0; mif.rs_val = 0; mif.rt_val = 0; mif.md_in_d = 1'b1;
    tick; tick;
    reset = 1'b0; #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", mif.busy); end
    checks++; if ({mif.hi, mif.lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h exp 0", {mif.hi, mif.lo}); end
    checks++; if (mif.stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", mif.stall_md); end
    mif.md_in_d = 1'b0;
    tick;
    // reset in the middle of a mult
    mif.start = 1'b1; mif.op = 3'd0; mif.rs_val = 32'hFFFFFFFE; mif.rt_val = 32'd3;
    tick; mif.start = 1'b0;
    tick;
    reset = 1'b1; tick; tick; reset = 1'b0;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b exp 0", mif.busy); end
    repeat (12) tick;
    checks++; if ({mif.hi, mif.lo} !== 64'd0 || mif.busy !== 1'b0)
      begin errors++; $display("FAIL midreset_nocommit: got hilo=%h busy=%b exp 0/0", {mif.hi, mif.lo}, mif.busy); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult_div;
    logic [2:0]  t_op[7]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3};
    logic [31:0] t_rs[7]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'd100};
    logic [31:0] t_rt[7]  = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd9};
    logic [63:0] t_exp[7] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA, 64'hFFFFFFFF_FFFFFFFD,
                              64'h0, 64'h00000000_80000000, 64'h00000001_FFFFFFFD, 64'h00000001_0000000B};
    int ncyc[7] = '{5, 5, 10, 10, 10, 10, 10};
    int n; bit leak; logic [63:0] exp;
    for (int i = 0; i < 7; i++) begin
      exp = (i == 3) ? {m_hi, m_lo} : t_exp[i];   // divu by zero keeps HI/LO
      issue(t_op[i], t_rs[i], t_rt[i], exp);
      run_busy(n, leak);
      checks++; if (n !== ncyc[i]) begin errors++; $display("FAIL md_cycles[%0d]: got %0d exp %0d", i, n, ncyc[i]); end
      checks++; if (leak) begin errors++; $display("FAIL md_early[%0d]: got early hi/lo change exp none", i); end
      exp = sb_q.pop_front();
      checks++; if ({mif.hi, mif.lo} !== exp) begin errors++; $display("FAIL md_result[%0d]: got %h exp %h", i, {mif.hi, mif.lo}, exp); end
      {m_hi, m_lo} = exp;
      tick;
    end
  endtask

  task automatic test_stall;
    int n; bit leak; logic [63:0] exp;
    mif.md_in_d = 1'b1;
    mif.start = 1'b1; mif.op = 3'd1; mif.rs_val = 32'd6; mif.rt_val = 32'd7; #1;
    checks++; if (mif.stall_md !== 1'b1) begin errors++; $display("FAIL stall_start: got %b exp 1", mif.stall_md); end
    sb_q.push_back(64'd42);
    tick; mif.start = 1'b0; #1;
    checks++; if (mif.stall_md !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b exp 1", mif.stall_md); end
    mif.md_in_d = 1'b0; #1;
    checks++; if (mif.stall_md !== 1'b0) begin errors++; $display("FAIL stall_nomd: got %b exp 0", mif.stall_md); end
    run_busy(n, leak);
    exp = sb_q.pop_front();
    checks++; if ({mif.hi, mif.lo} !== exp) begin errors++; $display("FAIL stall_result: got %h exp %h", {mif.hi, mif.lo}, exp); end
    {m_hi, m_lo} = exp;
    mif.md_in_d = 1'b1; #1;
    checks++; if (mif.stall_md !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b exp 0", mif.stall_md); end
    mif.start = 1'b1; mif.op = 3'd4; #1;
    checks++; if (mif.stall_md !== 1'b0) begin errors++; $display("FAIL stall_mthi: got %b exp 0", mif.stall_md); end
    mif.op = 3'd7; #1;
    checks++; if (mif.stall_md !== 1'b0) begin errors++; $display("FAIL stall_op7: got %b exp 0", mif.stall_md); end
    mif.start = 1'b0; mif.md_in_d = 1'b0;
    tick;
  endtask

  task automatic test_mt;
    mif.start = 1'b1; mif.op = 3'd4; mif.rs_val = 32'h1234;
    tick; mif.start = 1'b0;
    checks++; if (mif.hi !== 32'h1234 || mif.lo !== m_lo || mif.busy !== 1'b0)
      begin errors++; $display("FAIL mthi: got hi=%h lo=%h busy=%b exp 1234/%h/0", mif.hi, mif.lo, mif.busy, m_lo); end
    m_hi = 32'h1234;
    mif.start = 1'b1; mif.op = 3'd5; mif.rs_val = 32'h5678;
    tick; mif.start = 1'b0;
    checks++; if (mif.lo !== 32'h5678 || mif.hi !== m_hi || mif.busy !== 1'b0)
      begin errors++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b exp %h/5678/0", mif.hi, mif.lo, mif.busy, m_hi); end
    m_lo = 32'h5678;
  endtask

  task automatic test_reserved;
    int n; bit leak; logic [63:0] exp;
    mif.start = 1'b1; mif.op = 3'd7; mif.rs_val = 32'd100; mif.rt_val = 32'd7;
    tick; mif.start = 1'b0;
    checks++; if (mif.busy !== 1'b0 || {mif.hi, mif.lo} !== {m_hi, m_lo})
      begin errors++; $display("FAIL op7: got busy=%b hilo=%h exp 0/%h", mif.busy, {mif.hi, mif.lo}, {m_hi, m_lo}); end
`ifdef MDU_FASTDIV_EN
    issue(3'd6, 32'd100, 32'd7, {32'd2, 32'd14});
    run_busy(n, leak);
    checks++; if (n !== 3) begin errors++; $display("FAIL fdiv_cycles: got %0d exp 3", n); end
    exp = sb_q.pop_front();
    checks++; if ({mif.hi, mif.lo} !== exp) begin errors++; $display("FAIL fdiv_result: got %h exp %h", {mif.hi, mif.lo}, exp); end
    {m_hi, m_lo} = exp;
`else
    mif.start = 1'b1; mif.op = 3'd6;
    tick; mif.start = 1'b0;
    checks++; if (mif.busy !== 1'b0 || {mif.hi, mif.lo} !== {m_hi, m_lo})
      begin errors++; $display("FAIL op6_noop: got busy=%b hilo=%h exp 0/%h", mif.busy, {mif.hi, mif.lo}, {m_hi, m_lo}); end
    n = 0; leak = 0; exp = '0;
`endif
    tick;
  endtask

  task automatic test_start_in_run;
    int n; logic [63:0] exp;
    issue(3'd3, 32'd100, 32'd9, {32'd1, 32'd11});
    n = 0;
    while (mif.busy && n < 100) begin
      n++;
      mif.start = 1'b1;
      mif.op = (n % 2 == 0) ? 3'd4 : 3'd0;
      mif.rs_val = 32'hDEAD0000; mif.rt_val = 32'd5;
      tick;
    end
    mif.start = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("FAIL run_ignore_cycles: got %0d exp 10", n); end
    exp = sb_q.pop_front();
    checks++; if ({mif.hi, mif.lo} !== exp) begin errors++; $display("FAIL run_ignore_result: got %h exp %h", {mif.hi, mif.lo}, exp); end
    {m_hi, m_lo} = exp;
    tick;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL run_ignore_idle: got %b exp 0", mif.busy); end
  endtask

  task automatic test_back_to_back;
    int n; bit leak; logic [2:0] op; logic [31:0] rs, rt; logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      rs = $urandom;
      rt = (i == 3) ? 32'd0 : ((i == 5) ? 32'hFFFFFFFF : $urandom);
      issue(op, rs, rt, model(op, rs, rt, m_hi, m_lo));   // issued right after prior commit
      run_busy(n, leak);
      checks++; if (n !== ((op < 3'd2) ? 5 : 10)) begin errors++; $display("FAIL b2b_cycles[%0d]: got %0d op %0d", i, n, op); end
      exp = sb_q.pop_front();
      checks++; if ({mif.hi, mif.lo} !== exp || leak)
        begin errors++; $display("FAIL b2b_result[%0d]: got %h exp %h op=%0d rs=%h rt=%h", i, {mif.hi, mif.lo}, exp, op, rs, rt); end
      {m_hi, m_lo} = exp;
    end
  endtask

  initial begin
    test_reset;
    test_mult_div;
    test_stall;
    test_mt;
    test_reserved;
    test_start_in_run;
    test_back_to_back;
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d left exp 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
